// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-fill path between the
// I/D caches and the single-ported main memory.
package cache_pkg;

   localparam int ADDR_W = 16;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = 4;

   localparam logic [CNT_W-1:0]  WORDS      = 4'd8;
   localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      FILL,
      DONE
   } state_t;

endpackage

// File: rtl/fill_counter.sv
// Issue/return word counters for one block fill.
// Both saturate at WORDS and are cleared on a new grant.
module fill_counter
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             iss_inc,
   input  logic             ret_inc,
   output logic             issuing,
   output logic [IDX_W-1:0] iss_word,
   output logic [IDX_W-1:0] ret_word,
   output logic             ret_last
);

   logic [CNT_W-1:0] iss;
   logic [CNT_W-1:0] ret;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         iss <= '0;
         ret <= '0;
      end else begin
         if (iss_inc && issuing)
            iss <= iss + CNT_W'(1);
         if (ret_inc && (ret != WORDS))
            ret <= ret + CNT_W'(1);
      end
   end

   assign issuing  = (iss < WORDS);
   assign iss_word = iss[IDX_W-1:0];
   assign ret_word = ret[IDX_W-1:0];
   assign ret_last = (ret == (WORDS - CNT_W'(1)));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Main-memory owner: arbitrates I-miss, D-miss and D write-through,
// runs 8-word pipelined block fills and steers returns to the owner.
module mem_fill_arbiter
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_miss,
   input  logic [ADDR_W-1:0] ic_miss_addr,
   input  logic              dc_miss,
   input  logic [ADDR_W-1:0] dc_miss_addr,
   input  logic              dc_wr_req,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [15:0]       dc_wr_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_data_valid,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       fill_data,
   output logic              ic_fill_we,
   output logic [IDX_W-1:0]  ic_fill_word,
   output logic              ic_fill_done,
   output logic              dc_fill_we,
   output logic [IDX_W-1:0]  dc_fill_word,
   output logic              dc_fill_done,
   output logic              dc_wr_done,
   output logic              busy
);

   state_t            state;
   state_t            state_n;
   logic              own_d;
   logic [ADDR_W-1:0] base;

   logic              grant_fill;
   logic              grant_d;
   logic [ADDR_W-1:0] grant_addr;

   logic              iss_inc;
   logic              ret_inc;
   logic              issuing;
   logic [IDX_W-1:0]  iss_word;
   logic [IDX_W-1:0]  ret_word;
   logic              ret_last;

   fill_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (grant_fill),
      .iss_inc  (iss_inc),
      .ret_inc  (ret_inc),
      .issuing  (issuing),
      .iss_word (iss_word),
      .ret_word (ret_word),
      .ret_last (ret_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         own_d <= 1'b0;
         base  <= '0;
      end else begin
         state <= state_n;
         if (grant_fill) begin
            own_d <= grant_d;
            base  <= grant_addr & BLOCK_MASK;
         end
      end
   end

   always_comb begin
      state_n      = state;
      grant_fill   = 1'b0;
      grant_d      = 1'b0;
      grant_addr   = ic_miss_addr;
      iss_inc      = 1'b0;
      ret_inc      = 1'b0;
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      fill_data    = '0;
      ic_fill_we   = 1'b0;
      ic_fill_word = '0;
      ic_fill_done = 1'b0;
      dc_fill_we   = 1'b0;
      dc_fill_word = '0;
      dc_fill_done = 1'b0;
      dc_wr_done   = 1'b0;
      unique case (state)
         IDLE: begin
            // D-miss beats the store so a write-allocate fill lands first
            if (dc_miss) begin
               state_n    = FILL;
               grant_fill = 1'b1;
               grant_d    = 1'b1;
               grant_addr = dc_miss_addr;
            end else if (dc_wr_req) begin
               state_n = WRITE;
            end else if (ic_miss) begin
               state_n    = FILL;
               grant_fill = 1'b1;
            end
         end
         WRITE: begin
            mem_en     = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = dc_wr_addr;
            mem_wdata  = dc_wr_data;
            dc_wr_done = 1'b1;
            state_n    = IDLE;
         end
         FILL: begin
            fill_data = mem_rdata;
            if (issuing) begin
               mem_en   = 1'b1;
               iss_inc  = 1'b1;
               mem_addr = base + {{(ADDR_W-IDX_W-1){1'b0}}, iss_word, 1'b0};
            end
            if (mem_data_valid) begin
               ret_inc = 1'b1;
               if (own_d) begin
                  dc_fill_we   = 1'b1;
                  dc_fill_word = ret_word;
               end else begin
                  ic_fill_we   = 1'b1;
                  ic_fill_word = ret_word;
               end
               if (ret_last)
                  state_n = DONE;
            end
         end
         DONE: begin
            dc_fill_done = own_d;
            ic_fill_done = ~own_d;
            state_n      = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-cycle pipelined
// memory model; read data is address ^ 16'h5A5A.
module tb_mem_fill_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_miss, dc_miss, dc_wr_req;
   logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_data_valid;
   logic [15:0] mem_rdata, fill_data;
   logic        ic_fill_we, ic_fill_done, dc_fill_we, dc_fill_done;
   logic [2:0]  ic_fill_word, dc_fill_word;
   logic        dc_wr_done, busy;

   logic [3:0]  vpipe = '0;
   logic [15:0] dpipe [4];
   logic        spur;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      vpipe    <= {vpipe[2:0], mem_en & ~mem_wr};
      dpipe[0] <= mem_addr ^ 16'h5A5A;
      dpipe[1] <= dpipe[0];
      dpipe[2] <= dpipe[1];
      dpipe[3] <= dpipe[2];
   end

   assign mem_data_valid = vpipe[3] | spur;
   assign mem_rdata      = dpipe[3];

   mem_fill_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .ic_miss        (ic_miss),
      .ic_miss_addr   (ic_miss_addr),
      .dc_miss        (dc_miss),
      .dc_miss_addr   (dc_miss_addr),
      .dc_wr_req      (dc_wr_req),
      .dc_wr_addr     (dc_wr_addr),
      .dc_wr_data     (dc_wr_data),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_data_valid (mem_data_valid),
      .mem_rdata      (mem_rdata),
      .fill_data      (fill_data),
      .ic_fill_we     (ic_fill_we),
      .ic_fill_word   (ic_fill_word),
      .ic_fill_done   (ic_fill_done),
      .dc_fill_we     (dc_fill_we),
      .dc_fill_word   (dc_fill_word),
      .dc_fill_done   (dc_fill_done),
      .dc_wr_done     (dc_wr_done),
      .busy           (busy)
   );

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, {8'h0, mem_en, mem_wr, ic_fill_we, ic_fill_done,
          dc_fill_we, dc_fill_done, dc_wr_done, busy}, 16'h0);
      chk({tag, "_addr"}, mem_addr, 16'h0);
      chk({tag, "_wdata"}, mem_wdata, 16'h0);
      chk({tag, "_fdata"}, fill_data, 16'h0);
   endtask

   // Call just after the posedge that opens grant cycle T.
   task automatic fill_seq(input bit d, input logic [15:0] base);
      logic en_e, we_e;
      @(negedge clk);
      chk("grant_busy", {15'h0, busy}, 16'h0);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         en_e = (k <= 8);
         we_e = (k >= 5) && (k <= 12);
         chk("mem_en", {15'h0, mem_en}, {15'h0, en_e});
         chk("mem_wr", {15'h0, mem_wr}, 16'h0);
         chk("mem_addr", mem_addr, en_e ? base + 16'(2 * (k - 1)) : 16'h0);
         chk("own_we", {15'h0, d ? dc_fill_we : ic_fill_we}, {15'h0, we_e});
         chk("oth_we", {15'h0, d ? ic_fill_we : dc_fill_we}, 16'h0);
         if (we_e) begin
            chk("word", {13'h0, d ? dc_fill_word : ic_fill_word}, 16'(k - 5));
            chk("fdata", fill_data, (base + 16'(2 * (k - 5))) ^ 16'h5A5A);
         end
         chk("own_done", {15'h0, d ? dc_fill_done : ic_fill_done},
             {15'h0, k == 13});
         chk("oth_done", {15'h0, d ? ic_fill_done : dc_fill_done}, 16'h0);
         chk("wr_done", {15'h0, dc_wr_done}, 16'h0);
         chk("busy", {15'h0, busy}, 16'h1);
      end
      if (d) dc_miss = 1'b0;
      else   ic_miss = 1'b0;
   endtask

   task automatic write_chk(input logic [15:0] a, input logic [15:0] dat);
      chk("wr_en", {14'h0, mem_en, mem_wr}, 16'h3);
      chk("wr_addr", mem_addr, a);
      chk("wr_wdata", mem_wdata, dat);
      chk("wr_done", {15'h0, dc_wr_done}, 16'h1);
      chk("wr_fdone", {14'h0, ic_fill_done, dc_fill_done}, 16'h0);
      chk("wr_busy", {15'h0, busy}, 16'h1);
   endtask

   initial begin
      rst = 1'b1;
      spur = 1'b0;
      ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
      ic_miss_addr = '0; dc_miss_addr = '0;
      dc_wr_addr = '0; dc_wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      rst = 1'b0;

      // I-miss alone
      @(posedge clk); #1;
      ic_miss = 1'b1; ic_miss_addr = 16'h1236;
      fill_seq(1'b0, 16'h1230);

      // Simultaneous misses: D first, I granted at T+14
      @(posedge clk); #1;
      ic_miss = 1'b1; ic_miss_addr = 16'h0040;
      dc_miss = 1'b1; dc_miss_addr = 16'h8002;
      fill_seq(1'b1, 16'h8000);
      @(posedge clk); #1;
      fill_seq(1'b0, 16'h0040);

      // Store beats pending I-miss
      @(posedge clk); #1;
      dc_wr_req = 1'b1; dc_wr_addr = 16'h0010; dc_wr_data = 16'hBEEF;
      ic_miss = 1'b1; ic_miss_addr = 16'h0040;
      @(negedge clk);
      chk("st_grant_busy", {15'h0, busy}, 16'h0);
      @(negedge clk);
      write_chk(16'h0010, 16'hBEEF);
      dc_wr_req = 1'b0;
      @(posedge clk); #1;
      fill_seq(1'b0, 16'h0040);

      // D-miss with store: fill first, store afterwards
      @(posedge clk); #1;
      dc_miss = 1'b1; dc_miss_addr = 16'h2224;
      dc_wr_req = 1'b1; dc_wr_addr = 16'h2226; dc_wr_data = 16'h1234;
      fill_seq(1'b1, 16'h2220);
      @(negedge clk);
      chk("alloc_idle", {15'h0, busy}, 16'h0);
      @(negedge clk);
      write_chk(16'h2226, 16'h1234);
      dc_wr_req = 1'b0;

      // Reset at T+7 of a D fill
      @(posedge clk); #1;
      dc_miss = 1'b1; dc_miss_addr = 16'h3000;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1; dc_miss = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 8; k <= 14; k++) begin
         @(negedge clk);
         chk_quiet("rst_fill");
         @(posedge clk); #1;
      end

      // Spurious valid in IDLE, then a fill must start at word 0
      spur = 1'b1;
      @(negedge clk);
      chk("spur_we", {14'h0, ic_fill_we, dc_fill_we}, 16'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("spur_we2", {14'h0, ic_fill_we, dc_fill_we}, 16'h0);
      @(posedge clk); #1;
      spur = 1'b0;
      ic_miss = 1'b1; ic_miss_addr = 16'h4448;
      fill_seq(1'b0, 16'h4440);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
